mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It fetches an instruction over a req/ack instruction-memory handshake and latches it into inst_q, which drives the sign/zero-extend immediate unit and the register-file address fields. It then steps the shared ALU, data memory and register file through DECODE/EXEC/MEM/WB. Unsupported or malformed encodings park the core in a sticky TRAP state.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_opc_class.sv | 29 ++
 rtl/mc_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the mc_ctrl sequencer: opcode constants on inst[6:2],
// state encodings, one-hot opcode class indices and the pc_sel/wb_sel encodings.
package mc_ctrl_pkg;

  localparam int INSTRUCTION_WIDTH = 32;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam int NUM_CLS    = 9;
  localparam int CLS_LOAD   = 0;
  localparam int CLS_OP_IMM = 1;
  localparam int CLS_AUIPC  = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_OP     = 4;
  localparam int CLS_LUI    = 5;
  localparam int CLS_BRANCH = 6;
  localparam int CLS_JALR   = 7;
  localparam int CLS_JAL    = 8;

  typedef logic [NUM_CLS-1:0] cls_t;

  // Classes whose ALU operand B is the immediate, and classes that write rd.
  localparam cls_t ALU_IMM_MASK = cls_t'((1 << CLS_LOAD) | (1 << CLS_STORE) | (1 << CLS_OP_IMM) |
                                         (1 << CLS_JALR) | (1 << CLS_AUIPC));
  localparam cls_t RF_WRITE_MASK = cls_t'((1 << CLS_LOAD) | (1 << CLS_OP_IMM) | (1 << CLS_AUIPC) |
                                          (1 << CLS_OP) | (1 << CLS_LUI) | (1 << CLS_JALR) |
                                          (1 << CLS_JAL));

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

endpackage

// File: rtl/mc_opc_class.sv
// Combinational opcode classifier: inst[6:0] -> one-hot class vector plus a
// valid bit (32-bit encoding with a supported opcode).
module mc_opc_class
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] inst_i,
  output cls_t       cls_o,
  output logic       valid_o
);

  // Map the major opcode onto its class bit; unknown opcodes leave the vector empty.
  always_comb begin
    cls_o = '0;
    case (inst_i[6:2])
      OPC_LOAD:   cls_o[CLS_LOAD]   = 1'b1;
      OPC_OP_IMM: cls_o[CLS_OP_IMM] = 1'b1;
      OPC_AUIPC:  cls_o[CLS_AUIPC]  = 1'b1;
      OPC_STORE:  cls_o[CLS_STORE]  = 1'b1;
      OPC_OP:     cls_o[CLS_OP]     = 1'b1;
      OPC_LUI:    cls_o[CLS_LUI]    = 1'b1;
      OPC_BRANCH: cls_o[CLS_BRANCH] = 1'b1;
      OPC_JALR:   cls_o[CLS_JALR]   = 1'b1;
      OPC_JAL:    cls_o[CLS_JAL]    = 1'b1;
      default:    cls_o = '0;
    endcase
    valid_o = (inst_i[1:0] == 2'b11) && (cls_o != '0);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB, sticky TRAP).
// Define MC_TIMEOUT_EN to bound every memory wait to TIMEOUT cycles and trap with bus_err.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INST_WIDTH = INSTRUCTION_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst_q,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  input  logic                  branch_taken,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  alu_src_imm,
  output logic [1:0]            wb_sel,
  output logic                  rf_we,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [2:0]            state_o
);

  state_e                state_q, state_d;
  logic [INST_WIDTH-1:0] inst_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;

  cls_t fetch_cls_s, dec_cls_s;
  logic fetch_valid_s, dec_valid_s, fetch_ok_s;
  logic imem_req_s, dmem_req_s, dmem_we_s, pc_we_s, rf_we_s, alu_src_imm_s;
  logic [1:0] pc_sel_s, wb_sel_s;
  logic timeout_hit_s;

  mc_opc_class u_fetch_cls (
    .inst_i  (imem_rdata[6:0]),
    .cls_o   (fetch_cls_s),
    .valid_o (fetch_valid_s)
  );

  mc_opc_class u_dec_cls (
    .inst_i  (inst_q[6:0]),
    .cls_o   (dec_cls_s),
    .valid_o (dec_valid_s)
  );

  assign fetch_ok_s = fetch_valid_s && $onehot(fetch_cls_s);

`ifdef MC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Expiry is judged on the cycle whose increment would bring the count to TIMEOUT.
  assign timeout_hit_s = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // Wait counter: restarts on every state change, counts unanswered request cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((imem_req_s && !imem_ack) || (dmem_req_s && !dmem_ack)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and Moore output decode from state and the latched opcode class.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    imem_req_s    = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    pc_we_s       = 1'b0;
    rf_we_s       = 1'b0;
    alu_src_imm_s = 1'b0;
    pc_sel_s      = PC_SEL_PLUS4;
    wb_sel_s      = WB_SEL_ALU;
    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          inst_d = imem_rdata;
          if (fetch_ok_s) begin
            state_d = ST_DECODE;
          end else begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        end else if (timeout_hit_s) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_src_imm_s = |(dec_cls_s & ALU_IMM_MASK);
        if (dec_cls_s[CLS_LOAD] || dec_cls_s[CLS_STORE]) begin
          state_d = ST_MEM;
        end else if (dec_cls_s[CLS_BRANCH]) begin
          pc_we_s  = 1'b1;
          pc_sel_s = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // Operand B stays on the immediate so the address is stable for the whole access.
        alu_src_imm_s = |(dec_cls_s & ALU_IMM_MASK);
        dmem_req_s    = 1'b1;
        dmem_we_s     = dec_cls_s[CLS_STORE];
        if (dmem_ack) begin
          if (dec_cls_s[CLS_STORE]) begin
            pc_we_s = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit_s) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s = dec_valid_s && |(dec_cls_s & RF_WRITE_MASK);
        pc_we_s = 1'b1;
        if (dec_cls_s[CLS_LOAD]) begin
          wb_sel_s = WB_SEL_LOAD;
        end else if (dec_cls_s[CLS_JAL] || dec_cls_s[CLS_JALR]) begin
          wb_sel_s = WB_SEL_PC4;
        end else if (dec_cls_s[CLS_LUI]) begin
          wb_sel_s = WB_SEL_IMM;
        end else begin
          wb_sel_s = WB_SEL_ALU;
        end
        if (dec_cls_s[CLS_JAL]) begin
          pc_sel_s = PC_SEL_IMM;
        end else if (dec_cls_s[CLS_JALR]) begin
          pc_sel_s = PC_SEL_ALU;
        end else begin
          pc_sel_s = PC_SEL_PLUS4;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // State, instruction latch and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      inst_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobes drop combinationally with rst_n so an in-flight access is abandoned at once.
  assign imem_req    = imem_req_s & rst_n;
  assign dmem_req    = dmem_req_s & rst_n;
  assign pc_we       = pc_we_s & rst_n;
  assign rf_we       = rf_we_s & rst_n;
  assign dmem_we     = dmem_we_s;
  assign pc_sel      = pc_sel_s;
  assign wb_sel      = wb_sel_s;
  assign alu_src_imm = alu_src_imm_s;
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-cycle trace model built from instruction
// class rules drives the inputs and supplies the expected outputs for every cycle.
module tb_mc_ctrl;

  localparam int C_ILL = -1, C_LOAD = 0, C_OPIMM = 1, C_AUIPC = 2, C_STORE = 3, C_OP = 4;
  localparam int C_LUI = 5, C_BR = 6, C_JALR = 7, C_JAL = 8;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_A103;
  localparam logic [31:0] I_SW    = 32'h0020_A223;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_LUI   = 32'h1234_51B7;
  localparam logic [31:0] I_AUIPC = 32'h0000_1217;
  localparam logic [31:0] I_JAL   = 32'h0100_00EF;
  localparam logic [31:0] I_JALR  = 32'h0000_8067;
  localparam logic [31:0] I_ADD   = 32'h0020_82B3;

  typedef struct {
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] rdata;
    logic        dmem_ack;
    logic        taken;
    logic [2:0]  st;
    logic        imem_req, dmem_req, dmem_we, pc_we, rf_we, alu_imm, illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic        chk_inst;
    logic [31:0] inst;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n, imem_ack, dmem_ack, branch_taken;
  logic [31:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, pc_we, alu_src_imm, rf_we, illegal, bus_err;
  logic [31:0] inst_q;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state_o;

  cyc_t trace[$];
  cyc_t chk_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_illegal = 1'b0;
  logic m_bus_err = 1'b0;

  mc_ctrl #(.INST_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_q(inst_q), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_imm(alu_src_imm), .wb_sel(wb_sel), .rf_we(rf_we), .illegal(illegal),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] i);
    if (i[1:0] != 2'b11) return C_ILL;
    case (i[6:2])
      5'b00000: return C_LOAD;
      5'b00100: return C_OPIMM;
      5'b00101: return C_AUIPC;
      5'b01000: return C_STORE;
      5'b01100: return C_OP;
      5'b01101: return C_LUI;
      5'b11000: return C_BR;
      5'b11001: return C_JALR;
      5'b11011: return C_JAL;
      default:  return C_ILL;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t e;
    e.rst_n = 1'b1; e.imem_ack = 1'b0; e.rdata = 32'hA5A5_5A5A; e.dmem_ack = 1'b0;
    e.taken = 1'b0; e.st = st; e.imem_req = 1'b0; e.dmem_req = 1'b0; e.dmem_we = 1'b0;
    e.pc_we = 1'b0; e.rf_we = 1'b0; e.alu_imm = 1'b0; e.illegal = m_illegal;
    e.bus_err = m_bus_err; e.pc_sel = 2'd0; e.wb_sel = 2'd0; e.chk_inst = 1'b0; e.inst = 32'h0;
    return e;
  endfunction

  task automatic push_reset(input logic [2:0] st);
    cyc_t e = blank(st);
    e.rst_n = 1'b0; e.imem_ack = 1'b1; e.dmem_ack = 1'b1;
    trace.push_back(e);
    m_illegal = 1'b0;
    m_bus_err = 1'b0;
  endtask

  task automatic push_trap(input int n);
    for (int k = 0; k < n; k++) begin
      cyc_t e = blank(3'd5);
      e.imem_ack = 1'b1; e.dmem_ack = 1'b1; e.rdata = I_ADDI;
      trace.push_back(e);
    end
  endtask

  // One instruction: iwait fetch wait cycles, dwait data wait cycles, optional reset in MEM.
  task automatic plan(input logic [31:0] inst, input int iwait, input int dwait,
                      input logic taken, input int abort_mem);
    cyc_t e;
    int c = cls_of(inst);
    for (int k = 0; k <= iwait; k++) begin
      e = blank(3'd0);
      e.imem_req = 1'b1; e.dmem_ack = 1'b1; e.rdata = 32'h0000_0000;
      if (k == iwait) begin
        e.imem_ack = 1'b1; e.rdata = inst;
      end
      trace.push_back(e);
    end
    if (c == C_ILL) begin
      m_illegal = 1'b1;
      push_trap(3);
      push_reset(3'd5);
      return;
    end
    e = blank(3'd1);
    e.chk_inst = 1'b1; e.inst = inst; e.imem_ack = 1'b1; e.dmem_ack = 1'b1; e.taken = ~taken;
    trace.push_back(e);
    e = blank(3'd2);
    e.chk_inst = 1'b1; e.inst = inst; e.imem_ack = 1'b1; e.dmem_ack = 1'b1; e.taken = taken;
    e.alu_imm = (c == C_LOAD || c == C_STORE || c == C_OPIMM || c == C_JALR || c == C_AUIPC);
    if (c == C_BR) begin
      e.pc_we = 1'b1; e.pc_sel = taken ? 2'd1 : 2'd0;
      trace.push_back(e);
      return;
    end
    trace.push_back(e);
    if (c == C_LOAD || c == C_STORE) begin
      for (int k = 0; k <= dwait; k++) begin
        if (k == abort_mem) begin
          push_reset(3'd3);
          return;
        end
        e = blank(3'd3);
        e.chk_inst = 1'b1; e.inst = inst; e.imem_ack = 1'b1;
        e.dmem_req = 1'b1; e.dmem_we = (c == C_STORE);
        if (k == dwait) begin
          e.dmem_ack = 1'b1;
          if (c == C_STORE) begin
            e.pc_we = 1'b1; e.pc_sel = 2'd0;
          end
        end
        trace.push_back(e);
      end
      if (c == C_STORE) return;
    end
    e = blank(3'd4);
    e.chk_inst = 1'b1; e.inst = inst; e.imem_ack = 1'b1; e.dmem_ack = 1'b1;
    e.rf_we = 1'b1; e.pc_we = 1'b1;
    e.wb_sel = (c == C_LOAD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : (c == C_LUI) ? 2'd3 : 2'd0;
    e.pc_sel = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
    trace.push_back(e);
  endtask

  task automatic plan_len(input string name, input logic [31:0] inst, input int dwait,
                          input logic taken, input int exp_len);
    int n0 = trace.size();
    plan(inst, 0, dwait, taken, -1);
    check(name, 32'(trace.size() - n0), 32'(exp_len));
  endtask

  // Compare process: every cycle with a pending expectation is checked on the falling edge.
  always @(negedge clk) begin
    cyc_t ce;
    if (chk_q.size() > 0) begin
      ce = chk_q.pop_front();
      check("state_o", 32'(state_o), 32'(ce.st));
      check("imem_req", 32'(imem_req), 32'(ce.imem_req));
      check("dmem_req", 32'(dmem_req), 32'(ce.dmem_req));
      check("pc_we", 32'(pc_we), 32'(ce.pc_we));
      check("rf_we", 32'(rf_we), 32'(ce.rf_we));
      check("illegal", 32'(illegal), 32'(ce.illegal));
      check("bus_err", 32'(bus_err), 32'(ce.bus_err));
      if (ce.dmem_req) check("dmem_we", 32'(dmem_we), 32'(ce.dmem_we));
      if (ce.pc_we) check("pc_sel", 32'(pc_sel), 32'(ce.pc_sel));
      if (ce.rf_we) check("wb_sel", 32'(wb_sel), 32'(ce.wb_sel));
      if (ce.st == 3'd2) check("alu_src_imm", 32'(alu_src_imm), 32'(ce.alu_imm));
      if (ce.chk_inst) check("inst_q", inst_q, ce.inst);
    end
  end

  initial begin
    cyc_t e;
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; imem_rdata = 32'h0;

    // Latency of each class with zero memory wait, pinned to hand-counted cycles.
    plan_len("len_addi", I_ADDI, 0, 1'b0, 4);
    plan_len("len_lw_wait3", I_LW, 3, 1'b0, 8);
    plan_len("len_beq_taken", I_BEQ, 0, 1'b1, 3);
    plan_len("len_beq_not", I_BEQ, 0, 1'b0, 3);
    plan_len("len_sw", I_SW, 0, 1'b0, 4);
    plan_len("len_lw", I_LW, 0, 1'b0, 5);
    plan_len("len_lui", I_LUI, 0, 1'b0, 4);
    plan(I_AUIPC, 0, 0, 1'b0, -1);
    plan(I_JAL, 1, 0, 1'b0, -1);
    plan(I_JALR, 0, 0, 1'b1, -1);
    plan(I_ADD, 2, 0, 1'b0, -1);
    plan(I_SW, 1, 2, 1'b0, -1);
    plan(I_LW, 0, 3, 1'b0, 1);
    plan(I_ADDI, 0, 0, 1'b0, -1);
    plan(32'h0000_0000, 0, 0, 1'b0, -1);
    plan(32'h0000_007F, 1, 0, 1'b0, -1);
    plan(I_ADDI, 0, 0, 1'b0, -1);
`ifdef MC_TIMEOUT_EN
    plan(I_ADD, 15, 0, 1'b0, -1);
    for (int k = 0; k < 16; k++) begin
      e = blank(3'd0);
      e.imem_req = 1'b1;
      trace.push_back(e);
    end
    m_bus_err = 1'b1;
    push_trap(3);
    push_reset(3'd5);
`else
    plan(I_ADD, 20, 0, 1'b0, -1);
`endif
    plan(I_LW, 0, 1, 1'b0, -1);

    // Reset state, sampled while rst_n is still low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_inst_q", inst_q, 32'h0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_strobes", {28'h0, dmem_req, pc_we, rf_we, 1'b0}, 32'h0);

    while (trace.size() > 0) begin
      e = trace.pop_front();
      rst_n = e.rst_n; imem_ack = e.imem_ack; imem_rdata = e.rdata;
      dmem_ack = e.dmem_ack; branch_taken = e.taken;
      chk_q.push_back(e);
      @(posedge clk);
      #1;
    end
    check("chk_q_drained", 32'(chk_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
